dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter in front of the single-port 8-word data memory. Port 0 is the pipeline MEM stage; port 1 is the loader/debug port. The block grants at most one access per cycle, drives the memory's enables/address/data, and routes the 1-cycle-latency registered read data back to the issuing port. Port 1 has a starvation guard, and word addresses outside the memory are flagged as errors.

Parameters:
MAX_WAIT, 4, consecutive cycles port 1 may be denied before it takes priority over port 0 (1..15)
ADDR_LIMIT, 32'h0000_001F, highest legal byte address; above this is an error

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high
p0_req_valid  input  1  port 0 request present
p0_req_we  input  1  1=write, 0=read
p0_req_addr  input  32  byte address
p0_req_wdata  input  32  write data
p0_req_ready  output  1  port 0 request accepted this cycle (combinational)
p0_rsp_valid  output  1  port 0 response this cycle
p0_rsp_rdata  output  32  read data (0 for writes/errors)
p0_rsp_err  output  1  address was above ADDR_LIMIT
p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata, p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err  same as port 0, for port 1
mem_read_enable  output  1  to memory
mem_write_enable  output  1  to memory
mem_address  output  32  to memory (byte address, memory uses [4:2])
mem_write_data  output  32  to memory
mem_data  input  32  registered memory read data, valid one cycle after the read enable
p0_stall  output  1  p0_req_valid & ~p0_req_ready, for the hazard unit

Behaviour:
- Reset (async): owner state=IDLE, wait_cnt=0, all rsp_valid/rsp_err=0, rsp_rdata=0. Memory enables are 0 while reset is high.
- Arbitration (combinational, each cycle):
  - Port 1 wins if p1_req_valid and (wait_cnt>=MAX_WAIT or !p0_req_valid).
  - Otherwise port 0 wins if p0_req_valid.
  - Winner's req_ready=1; loser's req_ready=0. Exactly one grant at most.
- Memory drive for the granted request:
  - mem_address/mem_write_data = winner's address/data.
  - mem_write_enable=we, mem_read_enable=~we, if the address <= ADDR_LIMIT.
  - Illegal address: both enables 0 (memory untouched); the request still completes.
  - No grant: enables 0; mem_address and mem_write_data hold 0.
- wait_cnt:
  - Increments (saturating at 15) on each cycle p1_req_valid=1 and port 1 not granted.
  - Clears when port 1 is granted or p1_req_valid=0.
- Owner FSM (registered, encodes who issued last cycle): IDLE, OWN0, OWN1.
  - Next state = OWN0/OWN1 on grant to port 0/1, else IDLE.
  - Also registered: issued_we, issued_err.
- Response, the cycle after grant, for the port named by the owner state:
  - rsp_valid=1.
  - rsp_err=issued_err.
  - rsp_rdata = mem_data if the issue was a legal read, else 0.
  - Other port's rsp_valid=0, rdata=0.
  - IDLE: all rsp outputs 0.
- Throughput: back-to-back grants every cycle. The response for grant N appears in the same cycle that grant N+1 is issued.
- Ordering:
  - Read-after-write to the same address on consecutive cycles returns the new data, because the memory write commits at the edge before the read is sampled.
  - The write response carries rdata=0.
- Reset mid-operation: a pending response is discarded (no rsp_valid after reset deasserts). A write issued in the reset cycle is not performed.
- Requesters must hold valid/we/addr/wdata stable until ready; changing them while stalled is illegal (bench asserts).

Test Plan:
- Reset then p0 read addr 0x08 → p0_req_ready=1 same cycle; next cycle p0_rsp_valid=1, rdata=0x00000002, err=0.
- p0 write 0x0C data 0xDEADBEEF, then p0 read 0x0C on the next cycle → write rsp rdata=0, read rsp rdata=0xDEADBEEF.
- p0 and p1 both valid continuously, MAX_WAIT=4:
  - p0 granted for cycles 0–3; p1 granted on cycle 4; wait_cnt cleared; p0 granted again on cycle 5.
  - p0_stall=1 only on cycle 4.
- p1 read 0x40 (above limit) → mem enables stay 0; next cycle p1_rsp_valid=1, err=1, rdata=0; memory contents unchanged.
- p0 read granted, reset asserted before the next edge → after release, no rsp_valid on either port; FSM=IDLE; wait_cnt=0.
- Alternate p0 writes to 0x00..0x1C with p1 reads of the same addresses every cycle → each p1 read returns the value written by the preceding grant; no lost or duplicated responses.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 8-word data memory.
// Port 1 gains priority after MAX_WAIT denied cycles; bad addresses raise rsp_err.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT   = 4,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_001F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req_valid,
  input  logic        p0_req_we,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_req_ready,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req_valid,
  input  logic        p1_req_we,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_req_ready,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_data,
  output logic        p0_stall
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

  localparam logic [3:0] WAIT_LIM = MAX_WAIT[3:0];

  owner_t      state;
  logic [3:0]  wait_cnt;
  logic        issued_we;
  logic        issued_err;
  logic        grant0;
  logic        grant1;
  logic        granted;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        win_legal;
  logic [31:0] rsp_data;

  assign grant1  = p1_req_valid & ((wait_cnt >= WAIT_LIM) | ~p0_req_valid);
  assign grant0  = p0_req_valid & ~grant1;
  assign granted = grant0 | grant1;

  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;
  assign p0_stall     = p0_req_valid & ~grant0;

  // Select the winning request; zero when nobody is granted
  always_comb begin
    win_we    = 1'b0;
    win_addr  = 32'h0;
    win_wdata = 32'h0;
    if (grant1) begin
      win_we    = p1_req_we;
      win_addr  = p1_req_addr;
      win_wdata = p1_req_wdata;
    end else if (grant0) begin
      win_we    = p0_req_we;
      win_addr  = p0_req_addr;
      win_wdata = p0_req_wdata;
    end
  end

  assign win_legal = win_addr <= ADDR_LIMIT;

  assign mem_address      = win_addr;
  assign mem_write_data   = win_wdata;
  assign mem_write_enable = ~reset & granted & win_legal & win_we;
  assign mem_read_enable  = ~reset & granted & win_legal & ~win_we;

  // Count consecutive denied cycles of port 1, saturating at 15
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (p1_req_valid & ~grant1) begin
      if (wait_cnt != 4'hF) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  // Remember who issued this cycle and how, for next cycle's response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      issued_we  <= 1'b0;
      issued_err <= 1'b0;
    end else begin
      issued_we  <= win_we;
      issued_err <= granted & ~win_legal;
      if (grant1) begin
        state <= OWN1;
      end else if (grant0) begin
        state <= OWN0;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign rsp_data = (~issued_we & ~issued_err) ? mem_data : 32'h0;

  // Route the response to the port that issued last cycle
  always_comb begin
    p0_rsp_valid = 1'b0;
    p0_rsp_err   = 1'b0;
    p0_rsp_rdata = 32'h0;
    p1_rsp_valid = 1'b0;
    p1_rsp_err   = 1'b0;
    p1_rsp_rdata = 32'h0;
    case (state)
      OWN0: begin
        p0_rsp_valid = 1'b1;
        p0_rsp_err   = issued_err;
        p0_rsp_rdata = rsp_data;
      end
      OWN1: begin
        p1_rsp_valid = 1'b1;
        p1_rsp_err   = issued_err;
        p1_rsp_rdata = rsp_data;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset corner case,
// then randomized traffic checked against a transaction-level model.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam logic [31:0] LIMIT = 32'h1F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req_valid = 1'b0, p0_req_we = 1'b0;
  logic [31:0] p0_req_addr = '0, p0_req_wdata = '0;
  logic        p0_req_ready, p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_rsp_rdata;
  logic        p1_req_valid = 1'b0, p1_req_we = 1'b0;
  logic [31:0] p1_req_addr = '0, p1_req_wdata = '0;
  logic        p1_req_ready, p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_rsp_rdata;
  logic        mem_read_enable, mem_write_enable;
  logic [31:0] mem_address, mem_write_data;
  logic [31:0] mem_data = '0;
  logic        p0_stall;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(4), .ADDR_LIMIT(32'h0000_001F)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_req_ready(p0_req_ready), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_req_ready(p1_req_ready), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_data(mem_data), .p0_stall(p0_stall)
  );

  // 8-word memory, preloaded with word index, registered read data
  logic [31:0] mem [8] = '{32'd0, 32'd1, 32'd2, 32'd3,
                           32'd4, 32'd5, 32'd6, 32'd7};
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[4:2]] <= mem_write_data;
    if (mem_read_enable) mem_data <= mem[mem_address[4:2]];
  end

  // Requesters must not change a stalled request
  logic        s0h = 1'b0, s1h = 1'b0;
  logic [64:0] s0snap = '0, s1snap = '0;
  always @(posedge clk) begin
    if (!reset && s0h)
      assert (p0_req_valid && {p0_req_we, p0_req_addr, p0_req_wdata} == s0snap)
        else $error("p0 request changed while stalled");
    if (!reset && s1h)
      assert (p1_req_valid && {p1_req_we, p1_req_addr, p1_req_wdata} == s1snap)
        else $error("p1 request changed while stalled");
    s0h <= !reset && p0_req_valid && !p0_req_ready;
    s1h <= !reset && p1_req_valid && !p1_req_ready;
    s0snap <= {p0_req_we, p0_req_addr, p0_req_wdata};
    s1snap <= {p1_req_we, p1_req_addr, p1_req_wdata};
  end

  int n_total = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  task automatic set_p0(input logic v, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
    p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
  endtask

  task automatic set_p1(input logic v, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
    p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
  endtask

  typedef struct {
    logic v0, we0; logic [31:0] a0, d0;
    logic v1, we1; logic [31:0] a1, d1;
    logic r0, r1, st, re, wr;
    logic rv0, er0; logic [31:0] rd0;
    logic rv1, er1; logic [31:0] rd1;
  } vec_t;

  vec_t tbl [20];

  // Transaction-level reference model
  int          ref_mem [8];
  bit          pend_v;
  bit          pend_p;
  bit          pend_err;
  logic [31:0] pend_rd;
  int          denied;
  bit          last_g0, last_g1;

  task automatic model_reset();
    pend_v = 0; pend_p = 0; pend_err = 0; pend_rd = 0; denied = 0;
    for (int i = 0; i < 8; i++) ref_mem[i] = mem[i];
  endtask

  task automatic model_cycle();
    bit g0, g1, we, legal;
    logic [31:0] a, d;
    int idx;
    chk("rsp0_valid", 32'(p0_rsp_valid), 32'(pend_v && !pend_p));
    chk("rsp0_err", 32'(p0_rsp_err), 32'(pend_v && !pend_p && pend_err));
    chk("rsp0_rdata", p0_rsp_rdata, (pend_v && !pend_p) ? pend_rd : 32'h0);
    chk("rsp1_valid", 32'(p1_rsp_valid), 32'(pend_v && pend_p));
    chk("rsp1_err", 32'(p1_rsp_err), 32'(pend_v && pend_p && pend_err));
    chk("rsp1_rdata", p1_rsp_rdata, (pend_v && pend_p) ? pend_rd : 32'h0);
    g1 = p1_req_valid && (denied >= MAX_WAIT || !p0_req_valid);
    g0 = p0_req_valid && !g1;
    chk("ready0", 32'(p0_req_ready), 32'(g0));
    chk("ready1", 32'(p1_req_ready), 32'(g1));
    chk("stall", 32'(p0_stall), 32'(p0_req_valid && !g0));
    a  = g1 ? p1_req_addr : g0 ? p0_req_addr : 32'h0;
    d  = g1 ? p1_req_wdata : g0 ? p0_req_wdata : 32'h0;
    we = g1 ? p1_req_we : g0 ? p0_req_we : 1'b0;
    legal = (g0 || g1) && a <= LIMIT;
    chk("mem_addr", mem_address, a);
    chk("mem_wdata", mem_write_data, d);
    chk("mem_re", 32'(mem_read_enable), 32'(legal && !we));
    chk("mem_we", 32'(mem_write_enable), 32'(legal && we));
    idx = int'(a / 4) % 8;
    pend_v = g0 || g1;
    pend_p = g1;
    pend_err = pend_v && !legal;
    pend_rd = (legal && !we) ? 32'(ref_mem[idx]) : 32'h0;
    if (legal && we) ref_mem[idx] = int'(d);
    if (p1_req_valid && !g1) denied = (denied < 15) ? denied + 1 : 15;
    else denied = 0;
    last_g0 = g0; last_g1 = g1;
  endtask

  task automatic reset_pulse();
    set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 11);
    if (k < 8) return 32'(k * 4);
    if (k == 8) return 32'h1F;
    if (k == 9) return 32'h20;
    if (k == 10) return 32'h40;
    return 32'hFFFF_FFFC;
  endfunction

  initial begin
    //         v0 we0 a0     d0            v1 we1 a1     d1  r0 r1 st re wr rv0 er0 rd0           rv1 er1 rd1
    tbl[0]  = '{1, 0, 32'h08, 0,           0, 0, 0,      0,  1, 0, 0, 1, 0, 0, 0, 0,            0, 0, 0};
    tbl[1]  = '{1, 1, 32'h0C, 32'hDEADBEEF,0, 0, 0,      0,  1, 0, 0, 0, 1, 1, 0, 2,            0, 0, 0};
    tbl[2]  = '{1, 0, 32'h0C, 0,           0, 0, 0,      0,  1, 0, 0, 1, 0, 1, 0, 0,            0, 0, 0};
    tbl[3]  = '{0, 0, 0,      0,           0, 0, 0,      0,  0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0};
    tbl[4]  = '{0, 0, 0,      0,           1, 0, 32'h40, 0,  0, 1, 0, 0, 0, 0, 0, 0,            0, 0, 0};
    tbl[5]  = '{0, 0, 0,      0,           0, 0, 0,      0,  0, 0, 0, 0, 0, 0, 0, 0,            1, 1, 0};
    tbl[6]  = '{0, 0, 0,      0,           1, 0, 32'h10, 0,  0, 1, 0, 1, 0, 0, 0, 0,            0, 0, 0};
    tbl[7]  = '{0, 0, 0,      0,           0, 0, 0,      0,  0, 0, 0, 0, 0, 0, 0, 0,            1, 0, 4};
    tbl[8]  = '{1, 0, 32'h00, 0,           1, 0, 32'h04, 0,  1, 0, 0, 1, 0, 0, 0, 0,            0, 0, 0};
    tbl[9]  = '{1, 0, 32'h00, 0,           1, 0, 32'h04, 0,  1, 0, 0, 1, 0, 1, 0, 0,            0, 0, 0};
    tbl[10] = '{1, 0, 32'h00, 0,           1, 0, 32'h04, 0,  1, 0, 0, 1, 0, 1, 0, 0,            0, 0, 0};
    tbl[11] = '{1, 0, 32'h00, 0,           1, 0, 32'h04, 0,  1, 0, 0, 1, 0, 1, 0, 0,            0, 0, 0};
    tbl[12] = '{1, 0, 32'h00, 0,           1, 0, 32'h04, 0,  0, 1, 1, 1, 0, 1, 0, 0,            0, 0, 0};
    tbl[13] = '{1, 0, 32'h00, 0,           1, 0, 32'h04, 0,  1, 0, 0, 1, 0, 0, 0, 0,            1, 0, 1};
    tbl[14] = '{0, 0, 0,      0,           1, 0, 32'h04, 0,  0, 1, 0, 1, 0, 1, 0, 0,            0, 0, 0};
    tbl[15] = '{0, 0, 0,      0,           0, 0, 0,      0,  0, 0, 0, 0, 0, 0, 0, 0,            1, 0, 1};
    tbl[16] = '{1, 1, 32'h20, 32'h55,      0, 0, 0,      0,  1, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0};
    tbl[17] = '{1, 0, 32'h1C, 0,           0, 0, 0,      0,  1, 0, 0, 1, 0, 1, 1, 0,            0, 0, 0};
    tbl[18] = '{0, 0, 0,      0,           1, 0, 32'h1F, 0,  0, 1, 0, 1, 0, 1, 0, 7,            0, 0, 0};
    tbl[19] = '{0, 0, 0,      0,           0, 0, 0,      0,  0, 0, 0, 0, 0, 0, 0, 0,            1, 0, 7};

    // Reset state
    #2;
    chk("rst_rsp0_valid", 32'(p0_rsp_valid), 0);
    chk("rst_rsp1_valid", 32'(p1_rsp_valid), 0);
    chk("rst_rsp0_rdata", p0_rsp_rdata, 0);
    chk("rst_mem_re", 32'(mem_read_enable), 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      set_p0(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0);
      set_p1(tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d_ready0", i), 32'(p0_req_ready), 32'(tbl[i].r0));
      chk($sformatf("v%0d_ready1", i), 32'(p1_req_ready), 32'(tbl[i].r1));
      chk($sformatf("v%0d_stall", i), 32'(p0_stall), 32'(tbl[i].st));
      chk($sformatf("v%0d_re", i), 32'(mem_read_enable), 32'(tbl[i].re));
      chk($sformatf("v%0d_we", i), 32'(mem_write_enable), 32'(tbl[i].wr));
      chk($sformatf("v%0d_rv0", i), 32'(p0_rsp_valid), 32'(tbl[i].rv0));
      chk($sformatf("v%0d_er0", i), 32'(p0_rsp_err), 32'(tbl[i].er0));
      chk($sformatf("v%0d_rd0", i), p0_rsp_rdata, tbl[i].rd0);
      chk($sformatf("v%0d_rv1", i), 32'(p1_rsp_valid), 32'(tbl[i].rv1));
      chk($sformatf("v%0d_er1", i), 32'(p1_rsp_err), 32'(tbl[i].er1));
      chk($sformatf("v%0d_rd1", i), p1_rsp_rdata, tbl[i].rd1);
    end

    // Reset lands while a read response is pending
    @(posedge clk); #1;
    set_p0(1, 0, 32'h08, 0); set_p1(0, 0, 0, 0);
    @(negedge clk);
    chk("mid_ready0", 32'(p0_req_ready), 1);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    set_p0(1, 1, 32'h14, 32'hAAAA5555);
    @(negedge clk);
    chk("mid_write_blocked", 32'(mem_write_enable), 0);
    chk("mid_rsp0_in_reset", 32'(p0_rsp_valid), 0);
    set_p0(0, 0, 0, 0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    set_p0(1, 0, 32'h14, 0);
    @(negedge clk);
    chk("mid_rsp0_dropped", 32'(p0_rsp_valid), 0);
    chk("mid_rsp1_dropped", 32'(p1_rsp_valid), 0);
    chk("mid_ready0_after", 32'(p0_req_ready), 1);
    @(posedge clk); #1;
    set_p0(0, 0, 0, 0);
    @(negedge clk);
    chk("mid_mem_untouched", p0_rsp_rdata, 32'd5);

    // Alternating p0 writes / p1 reads over every word
    reset_pulse();
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      set_p0(1, 1, 32'(i * 4), $urandom); set_p1(0, 0, 0, 0);
      @(negedge clk);
      model_cycle();
      @(posedge clk); #1;
      set_p0(0, 0, 0, 0); set_p1(1, 0, 32'(i * 4), 0);
      @(negedge clk);
      model_cycle();
    end

    // Randomized traffic; a request is held until the model grants it
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (!p0_req_valid || last_g0) begin
        if ($urandom_range(0, 9) < 8)
          set_p0(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        else set_p0(0, 0, 0, 0);
      end
      if (!p1_req_valid || last_g1) begin
        if ($urandom_range(0, 9) < 5)
          set_p1(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        else set_p1(0, 0, 0, 0);
      end
      @(negedge clk);
      model_cycle();
    end

    @(posedge clk); #1;
    set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0);
    @(negedge clk);
    model_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
